// File: rtl/doce_pkg.sv
// doce_pkg: DoCE header layout, shared constants, receive FSM states and a saturating counter helper.
package doce_pkg;
  localparam int DST_LSB = 0;
  localparam int SRC_LSB = 48;
  localparam int LEN_LSB = 96;
  localparam int SEQ_LSB = 112;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] LEN_OVERHEAD = 16'd2;
  typedef enum logic [1:0] {HDR, FWD, DROP} rx_state_e;
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return &c ? c : c + 32'd1;
  endfunction
endpackage

// File: rtl/rx_out_reg.sv
// rx_out_reg: 1-deep AXI-Stream register slice carrying data, keep, last and user.
module rx_out_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW*8-1:0] in_data_i,
  input  logic [DW-1:0] in_keep_i,
  input  logic          in_last_i,
  input  logic [16:0]   in_user_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW*8-1:0] out_data_o,
  output logic [DW-1:0] out_keep_o,
  output logic          out_last_o,
  output logic [16:0]   out_user_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);
  logic [DW*8-1:0] data_q;
  logic [DW-1:0] keep_q;
  logic last_q, valid_q;
  logic [16:0] user_q;
  assign in_ready_o = ~valid_q | out_ready_i;
  assign {out_data_o, out_keep_o, out_last_o, out_user_o, out_valid_o} = {data_q, keep_q, last_q, user_q, valid_q};
  // a push in the same cycle as a pop overwrites the entry, so no bubble is inserted
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      user_q <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q <= in_data_i;
      keep_q <= in_keep_i;
      last_q <= in_last_i;
      user_q <= in_user_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/rx_fsm.sv
// rx_fsm: parses and strips the DoCE MAC header beat, filters on destination MAC,
// forwards payload with recovered length in tuser, and tracks sequence/drop statistics.
module rx_fsm
  import doce_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    user_clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH*8-1:0] axi_str_tdata_from_router,
  input  logic [DATA_WIDTH-1:0]   axi_str_tkeep_from_router,
  input  logic                    axi_str_tvalid_from_router,
  input  logic                    axi_str_tlast_from_router,
  output logic                    axi_str_tready_to_router,
  output logic [DATA_WIDTH*8-1:0] axi_str_tdata_to_trans,
  output logic [DATA_WIDTH-1:0]   axi_str_tkeep_to_trans,
  output logic                    axi_str_tvalid_to_trans,
  output logic                    axi_str_tlast_to_trans,
  output logic [16:0]             axi_str_tuser_to_trans,
  input  logic                    axi_str_tready_from_trans,
  input  logic [47:0]             doce_mac_addr,
  output logic [47:0]             rx_src_mac_addr,
  output logic [31:0]             pkt_recv_cnt,
  output logic [31:0]             pkt_drop_cnt,
  output logic [31:0]             seq_err_cnt
);
  rx_state_e state_q;
  logic [16:0] tuser_q;
  logic [47:0] src_q;
  logic [31:0] recv_q, drop_q, err_q;
  logic [15:0] exp_q;
  logic synced_q;
  logic out_rdy, rx_fire, hit;
  logic [47:0] hdr_dst, hdr_src;
  logic [15:0] hdr_len, hdr_seq, len_adj;
  assign hdr_dst = axi_str_tdata_from_router[DST_LSB +: 48];
  assign hdr_src = axi_str_tdata_from_router[SRC_LSB +: 48];
  assign hdr_len = {axi_str_tdata_from_router[LEN_LSB +: 8], axi_str_tdata_from_router[LEN_LSB+8 +: 8]};
  assign hdr_seq = axi_str_tdata_from_router[SEQ_LSB +: 16];
  assign len_adj = hdr_len - LEN_OVERHEAD;
  assign hit = (hdr_dst == doce_mac_addr) || (hdr_dst == MAC_BCAST);
  assign axi_str_tready_to_router = (state_q == FWD) ? out_rdy : 1'b1;
  assign rx_fire = axi_str_tvalid_from_router && axi_str_tready_to_router;
  assign {rx_src_mac_addr, pkt_recv_cnt, pkt_drop_cnt, seq_err_cnt} = {src_q, recv_q, drop_q, err_q};
  rx_out_reg #(.DW(DATA_WIDTH)) u_out (
    .clk         (user_clk),
    .rst         (reset),
    .in_data_i   (axi_str_tdata_from_router),
    .in_keep_i   (axi_str_tkeep_from_router),
    .in_last_i   (axi_str_tlast_from_router),
    .in_user_i   (tuser_q),
    .in_valid_i  (axi_str_tvalid_from_router && state_q == FWD),
    .in_ready_o  (out_rdy),
    .out_data_o  (axi_str_tdata_to_trans),
    .out_keep_o  (axi_str_tkeep_to_trans),
    .out_last_o  (axi_str_tlast_to_trans),
    .out_user_o  (axi_str_tuser_to_trans),
    .out_valid_o (axi_str_tvalid_to_trans),
    .out_ready_i (axi_str_tready_from_trans)
  );
  // runt headers (tlast on the header beat) are dropped even when the MAC matches
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_q <= HDR;
      tuser_q <= '0;
      src_q <= '0;
      recv_q <= '0;
      drop_q <= '0;
      err_q <= '0;
      exp_q <= '0;
      synced_q <= 1'b0;
    end else begin
      case (state_q)
        HDR: if (rx_fire) begin
          if (axi_str_tlast_from_router) begin
            drop_q <= sat_inc(drop_q);
          end else if (hit) begin
            state_q <= FWD;
            recv_q <= sat_inc(recv_q);
            src_q <= hdr_src;
            tuser_q <= {len_adj[12:0], 4'b0};
            synced_q <= 1'b1;
            exp_q <= hdr_seq + 16'd1;
            if (synced_q && hdr_seq != exp_q) err_q <= sat_inc(err_q);
          end else begin
            state_q <= DROP;
            drop_q <= sat_inc(drop_q);
          end
        end
        FWD, DROP: if (rx_fire && axi_str_tlast_from_router) state_q <= HDR;
        default: state_q <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm: directed self-checking bench for rx_fsm with a beat-capturing output monitor.
module tb_rx_fsm;
  import doce_pkg::*;
  localparam logic [47:0] MY_MAC = 48'h0A0B0C0D0E0F;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [127:0] in_data = '0;
  logic [15:0] in_keep = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [127:0] out_data;
  logic [15:0] out_keep;
  logic out_valid, out_last;
  logic [16:0] out_user;
  logic out_ready = 1'b1;
  logic [47:0] src_mac;
  logic [31:0] recv_cnt, drop_cnt, err_cnt;
  int tests = 0, fails = 0, stall_err = 0;
  bit rand_rdy = 1'b0;
  logic [127:0] got_data[$];
  logic [15:0] got_keep[$];
  logic got_last[$];
  logic [16:0] got_user[$];
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [127:0] pd = '0;
  logic [15:0] pk = '0;
  logic [16:0] pu = '0;

  rx_fsm dut (
    .user_clk(clk), .reset(reset),
    .axi_str_tdata_from_router(in_data), .axi_str_tkeep_from_router(in_keep),
    .axi_str_tvalid_from_router(in_valid), .axi_str_tlast_from_router(in_last),
    .axi_str_tready_to_router(in_ready),
    .axi_str_tdata_to_trans(out_data), .axi_str_tkeep_to_trans(out_keep),
    .axi_str_tvalid_to_trans(out_valid), .axi_str_tlast_to_trans(out_last),
    .axi_str_tuser_to_trans(out_user), .axi_str_tready_from_trans(out_ready),
    .doce_mac_addr(MY_MAC), .rx_src_mac_addr(src_mac),
    .pkt_recv_cnt(recv_cnt), .pkt_drop_cnt(drop_cnt), .seq_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && pv && !pr && (!out_valid || out_data !== pd || out_keep !== pk || out_last !== pl || out_user !== pu))
      stall_err <= stall_err + 1;
    if (!reset && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_keep.push_back(out_keep);
      got_last.push_back(out_last);
      got_user.push_back(out_user);
    end
    pv <= out_valid & ~reset;
    pr <= out_ready;
    pd <= out_data;
    pk <= out_keep;
    pl <= out_last;
    pu <= out_user;
  end

  function automatic logic [127:0] hdr(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] len, input logic [15:0] seq);
    return {seq, len[7:0], len[15:8], src, dst};
  endfunction

  task automatic clear_q();
    got_data.delete();
    got_keep.delete();
    got_last.delete();
    got_user.delete();
  endtask

  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
    int n = 0;
    logic hs;
    @(negedge clk);
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    in_data = d;
    in_keep = k;
    in_last = l;
    in_valid = 1'b1;
    #1 hs = in_ready;
    while (!hs && n < 200) begin
      @(negedge clk);
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      n++;
      #1 hs = in_ready;
    end
    tests++;
    if (!hs) begin
      fails++;
      $display("FAIL send_timeout: tready_to_router stayed %b, required 1", hs);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", out_valid); end
    tests++; if (out_data !== '0 || out_keep !== '0 || out_last !== 1'b0) begin fails++; $display("FAIL reset_data: got %h/%h/%b want 0", out_data, out_keep, out_last); end
    tests++; if (out_user !== 17'd0) begin fails++; $display("FAIL reset_tuser: got %h want 0", out_user); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_tready: got %b want 1", in_ready); end
    tests++; if (recv_cnt !== 0 || drop_cnt !== 0 || err_cnt !== 0 || src_mac !== '0) begin fails++; $display("FAIL reset_counters: got %0d/%0d/%0d src %h want 0", recv_cnt, drop_cnt, err_cnt, src_mac); end
  endtask

  task automatic test_forward();
    clear_q();
    send(hdr(MY_MAC, 48'h112233445566, 16'h0042, 16'd5), 16'hFFFF, 1'b0);
    send({8{16'hA001}}, 16'hFFFF, 1'b0);
    send({8{16'hA002}}, 16'hFFFF, 1'b0);
    send({8{16'hA003}}, 16'h00FF, 1'b1);
    idle(3);
    tests++;
    if (got_data.size() != 3) begin fails++; $display("FAIL fwd_count: got %0d beats want 3", got_data.size()); end
    else begin
      tests++; if (got_data[0] !== {8{16'hA001}} || got_data[2] !== {8{16'hA003}}) begin fails++; $display("FAIL fwd_data: got %h %h", got_data[0], got_data[2]); end
      tests++; if (got_keep[2] !== 16'h00FF || got_last[2] !== 1'b1 || got_last[0] !== 1'b0) begin fails++; $display("FAIL fwd_keep_last: got %h %b want 00ff 1", got_keep[2], got_last[2]); end
      tests++; if (got_user[0] !== 17'h00400 || got_user[2] !== 17'h00400) begin fails++; $display("FAIL fwd_tuser: got %h want 00400", got_user[0]); end
    end
    tests++; if (src_mac !== 48'h112233445566) begin fails++; $display("FAIL fwd_src_mac: got %h want 112233445566", src_mac); end
    tests++; if (recv_cnt !== 32'd1) begin fails++; $display("FAIL fwd_recv_cnt: got %0d want 1", recv_cnt); end
  endtask

  task automatic test_drop();
    clear_q();
    send(hdr(48'h000000000001, 48'h777777777777, 16'h0010, 16'd99), 16'hFFFF, 1'b0);
    for (int i = 0; i < 4; i++) send({8{16'hD000 + 16'(i)}}, 16'hFFFF, i == 3);
    idle(3);
    tests++; if (got_data.size() != 0) begin fails++; $display("FAIL drop_no_output: got %0d beats want 0", got_data.size()); end
    tests++; if (drop_cnt !== 32'd1) begin fails++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
    tests++; if (dut.state_q !== HDR) begin fails++; $display("FAIL drop_state: got %0d want HDR", dut.state_q); end
    tests++; if (src_mac !== 48'h112233445566) begin fails++; $display("FAIL drop_src_kept: got %h want 112233445566", src_mac); end
    send(hdr(MY_MAC, 48'h222222222222, 16'h0012, 16'd6), 16'hFFFF, 1'b0);
    send({8{16'hB001}}, 16'h0003, 1'b1);
    idle(3);
    tests++; if (got_data.size() != 1 || recv_cnt !== 32'd2) begin fails++; $display("FAIL drop_then_fwd: got %0d beats recv %0d want 1 2", got_data.size(), recv_cnt); end
  endtask

  task automatic test_bcast();
    clear_q();
    send(hdr(MAC_BCAST, 48'h333333333333, 16'h0004, 16'd7), 16'hFFFF, 1'b0);
    send({8{16'hC001}}, 16'hFFFF, 1'b0);
    send({8{16'hC002}}, 16'hFFFF, 1'b1);
    idle(3);
    tests++; if (got_data.size() != 2) begin fails++; $display("FAIL bcast_count: got %0d want 2", got_data.size()); end
    tests++; if (recv_cnt !== 32'd3 || src_mac !== 48'h333333333333) begin fails++; $display("FAIL bcast_recv: got %0d src %h want 3 333333333333", recv_cnt, src_mac); end
  endtask

  task automatic test_runt();
    clear_q();
    send(hdr(MY_MAC, 48'h444444444444, 16'h0010, 16'd8), 16'hFFFF, 1'b1);
    idle(2);
    tests++; if (drop_cnt !== 32'd2 || recv_cnt !== 32'd3) begin fails++; $display("FAIL runt_counts: got drop %0d recv %0d want 2 3", drop_cnt, recv_cnt); end
    tests++; if (got_data.size() != 0 || dut.state_q !== HDR) begin fails++; $display("FAIL runt_state: got %0d beats state %0d want 0 HDR", got_data.size(), dut.state_q); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send(hdr(MY_MAC, 48'h555555555555, 16'h0001, 16'd8), 16'hFFFF, 1'b0);
    send({8{16'hE001}}, 16'hFFFF, 1'b1);
    send(hdr(MY_MAC, 48'h666666666666, 16'h0002, 16'd9), 16'hFFFF, 1'b0);
    send({8{16'hE002}}, 16'hFFFF, 1'b0);
    send({8{16'hE003}}, 16'h0001, 1'b1);
    idle(3);
    tests++;
    if (got_data.size() != 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", got_data.size()); end
    else begin
      tests++; if (got_user[0] !== 17'h1FFF0) begin fails++; $display("FAIL b2b_len_wrap: got %h want 1fff0", got_user[0]); end
      tests++; if (got_user[1] !== 17'h0 || got_user[2] !== 17'h0 || got_data[1] !== {8{16'hE002}}) begin fails++; $display("FAIL b2b_second: got %h %h", got_user[1], got_data[1]); end
    end
    tests++; if (recv_cnt !== 32'd5 || err_cnt !== 32'd0) begin fails++; $display("FAIL b2b_counts: got recv %0d err %0d want 5 0", recv_cnt, err_cnt); end
  endtask

  task automatic test_stall();
    int bad = 0;
    clear_q();
    rand_rdy = 1'b1;
    send(hdr(MY_MAC, 48'h888888888888, 16'h0142, 16'd10), 16'hFFFF, 1'b0);
    for (int i = 0; i < 20; i++) send({8{16'h5000 + 16'(i)}}, 16'hFFFF, i == 19);
    idle(40);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(3);
    tests++;
    if (got_data.size() != 20) begin fails++; $display("FAIL stall_count: got %0d want 20", got_data.size()); end
    else begin
      for (int i = 0; i < 20; i++)
        if (got_data[i] !== {8{16'h5000 + 16'(i)}} || got_last[i] !== (i == 19) || got_user[i] !== 17'h01400) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL stall_order: got %0d bad beats want 0", bad); end
    end
    tests++; if (stall_err != 0) begin fails++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_err); end
  endtask

  task automatic test_seq();
    logic [15:0] seqs [5] = '{16'd7, 16'd8, 16'd10, 16'hFFFF, 16'h0000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(hdr(MY_MAC, 48'h999999999999, 16'h0003, seqs[i]), 16'hFFFF, 1'b0);
      send({8{16'h7000 + 16'(i)}}, 16'h0001, 1'b1);
      if (i == 1) begin
        idle(1);
        tests++; if (err_cnt !== 32'd0) begin fails++; $display("FAIL seq_first_sync: got %0d want 0", err_cnt); end
      end
      if (i == 3) begin
        idle(1);
        tests++; if (err_cnt !== 32'd2) begin fails++; $display("FAIL seq_gap: got %0d want 2", err_cnt); end
      end
    end
    idle(2);
    tests++; if (err_cnt !== 32'd2) begin fails++; $display("FAIL seq_wrap: got %0d want 2", err_cnt); end
    tests++; if (recv_cnt !== 32'd5) begin fails++; $display("FAIL seq_recv: got %0d want 5", recv_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(hdr(MY_MAC, 48'hABABABABABAB, 16'h0010, 16'd1), 16'hFFFF, 1'b0);
    send({8{16'h6001}}, 16'hFFFF, 1'b0);
    @(negedge clk);
    in_data = {8{16'h6002}};
    in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid: got %b want 0", out_valid); end
    tests++; if (recv_cnt !== 0 || drop_cnt !== 0 || err_cnt !== 0) begin fails++; $display("FAIL rstmid_counters: got %0d/%0d/%0d want 0", recv_cnt, drop_cnt, err_cnt); end
    tests++; if (dut.state_q !== HDR || in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_state: got %0d ready %b want HDR 1", dut.state_q, in_ready); end
    in_valid = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_drop();
    test_bcast();
    test_runt();
    test_back_to_back();
    test_stall();
    test_seq();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rx_fsm.md
# rx_fsm

Receive-side counterpart of the DoCE transport-layer transmit path. It accepts Ethernet-level frames from the router, parses and strips the 128-bit MAC header beat, and filters on destination MAC. Accepted payload beats go to the transport layer with length recovered into `tuser`. It also tracks the per-link packet sequence number and keeps receive, drop and sequence-error counters.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: stream width in bytes; must be ≥ 16.

Ports:
- `user_clk`, in, 1: single clock for all logic.
- `reset`, in, 1: synchronous, active-high.
- `axi_str_tdata_from_router`, in, DATA_WIDTH*8: frame data.
- `axi_str_tkeep_from_router`, in, DATA_WIDTH: byte enables.
- `axi_str_tvalid_from_router`, in, 1: beat valid.
- `axi_str_tlast_from_router`, in, 1: last beat of frame.
- `axi_str_tready_to_router`, out, 1: beat accepted when high with valid.
- `axi_str_tdata_to_trans`, out, DATA_WIDTH*8: payload data.
- `axi_str_tkeep_to_trans`, out, DATA_WIDTH: payload byte enables.
- `axi_str_tvalid_to_trans`, out, 1: payload valid.
- `axi_str_tlast_to_trans`, out, 1: last payload beat.
- `axi_str_tuser_to_trans`, out, 17: bits [16:4] carry payload length; bits [3:0] = 0.
- `axi_str_tready_from_trans`, in, 1: transport ready.
- `doce_mac_addr`, in, 48: local MAC.
- `rx_src_mac_addr`, out, 48: source MAC of the last accepted packet.
- `pkt_recv_cnt`, out, 32: packets accepted.
- `pkt_drop_cnt`, out, 32: packets dropped.
- `seq_err_cnt`, out, 32: sequence discontinuities.

## Operation
- Header beat is the first beat of each frame, bits [127:0]:
  - [47:0] dst MAC.
  - [95:48] src MAC.
  - [111:96] frame length, byte-swapped: `len = {hdr[103:96], hdr[111:104]}`.
  - [127:112] sequence number.
  - Bits above 127 of the header beat are ignored.
- FSM states: `HDR` (reset), `FWD`, `DROP`.
- `HDR`: `tready_to_router` = 1.
  - Header with tlast = 1 (runt): `pkt_drop_cnt`++, stay in `HDR`.
  - Dst matches `doce_mac_addr` or equals 48'hFFFF_FFFF_FFFF:
    - `pkt_recv_cnt`++; latch src MAC into `rx_src_mac_addr`.
    - Latch `tuser[16:4] = len − 2` (13-bit, wraps modulo 2^13); go to `FWD`.
  - Any other dst: `pkt_drop_cnt`++, go to `DROP`.
- `FWD`:
  - Payload beats pass through unmodified (data, keep, last); tuser holds constant for the whole packet.
  - The beat with tlast returns the FSM to `HDR`.
- `DROP`: `tready_to_router` = 1; beats are discarded; tlast returns the FSM to `HDR`.
- Sequence check, on each accepted (MAC-matched) header only:
  - First accepted header after reset sets `seq_synced`; no error is counted.
  - Afterwards, `seq ≠ expected` → `seq_err_cnt`++.
  - Always set `expected ← seq + 1`; 16'hFFFF wraps to 0.
  - Dropped packets do not affect `expected`.
- All counters are 32-bit and saturate at 32'hFFFF_FFFF.

## Timing
- Output is a 1-deep register stage. Latency from an accepted payload beat at the input to `tvalid_to_trans` is 1 cycle.
- In `FWD`: `tready_to_router = ~out_valid | axi_str_tready_from_trans` (combinational). Sustained throughput is 1 beat/cycle.
- Output register update rules:
  - Holds data, keep, last and user stable while `valid & ~ready`.
  - Simultaneous pop and push in the same cycle replaces the entry with no bubble.
- A header in `HDR` is consumed in 1 cycle regardless of downstream stall. The next beat can enter `FWD` the following cycle; it is stalled only by the output register.
- `rx_src_mac_addr` and the counters update on the cycle after the header handshake.
- Reset values:
  - FSM to `HDR`; `axi_str_tvalid_to_trans` = 0.
  - tdata, tkeep and tlast to trans = 0; `tuser` = 0.
  - All counters = 0; `rx_src_mac_addr` = 0; `seq_synced` = 0; `expected` = 0.
  - `tready_to_router` = 1 (combinational from state).
- Reset mid-packet: any in-flight output beat is discarded. Remaining router beats of that frame are parsed as a new header; upstream must reset together with this block.

## Structure
- Shared package `doce_pkg` holds:
  - Header field offsets (DST_LSB = 0, SRC_LSB = 48, LEN_LSB = 96, SEQ_LSB = 112).
  - `MAC_BCAST` = 48'hFFFF_FFFF_FFFF.
  - `LEN_OVERHEAD` = 2 (shared with the transmit side).
  - State encodings `HDR` / `FWD` / `DROP`.
- One sub-module: `rx_out_reg`, the 1-deep AXI-Stream register slice carrying data, keep, last and user.

## Test plan
- `doce_mac_addr = 0x0A0B0C0D0E0F`; header dst = that address, src = 0x112233445566, len field bytes {0x00, 0x42}, seq = 5; then 3 payload beats, last with tkeep = 16'h00FF. Required: 3 output beats with tuser[16:4] = 0x40, `rx_src_mac_addr` = 0x112233445566, `pkt_recv_cnt` = 1.
- Header with dst = 0x000000000001, followed by 4 beats. Required: no output beats, `pkt_drop_cnt` = 1, FSM back in `HDR`; a following valid packet is forwarded.
- Broadcast dst header. Required: packet forwarded and `pkt_recv_cnt` incremented.
- Accepted headers with seq 7, 8, 10, then 0xFFFF, 0x0000. Required: `seq_err_cnt` = 2 (at 10 and at 0xFFFF); the 0xFFFF → 0 transition counts no error.
- `axi_str_tready_from_trans` toggled randomly across a 20-beat packet. Required: all beats delivered in order with no duplication or loss, and output held stable while stalled.
- Reset asserted on the second payload beat. Required: `tvalid_to_trans` = 0 and all counters = 0 on the next cycle, FSM in `HDR`.
